// File: rtl/knight_rider_scanner.sv
// Knight Rider LED scanner: a single lit LED sweeps up and down the bar, one step per TICK while RUN is high.
// Optional trailing LED is enabled by defining KRS_TAIL_EN.
module knight_rider_scanner #(
    parameter int NLEDS = 10,
    parameter int DWELL = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             TICK,
    input  logic             RUN,
    output logic [NLEDS-1:0] LED,
    output logic [3:0]       POS,
    output logic             DIR,
    output logic             WRAP
);

    typedef enum logic [1:0] {UP, HOLD_HI, DOWN, HOLD_LO} state_t;

    localparam logic [3:0]       PMAX = 4'(NLEDS - 1);
    localparam logic [3:0]       DW   = 4'(DWELL);
    localparam logic [NLEDS-1:0] ONE  = {{(NLEDS-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [3:0]       pos, pos_n;
    logic [3:0]       cnt, cnt_n;
    logic             dir, dir_n;
    logic             wrap, wrap_n;
    logic [NLEDS-1:0] led, led_n;
    logic             adv;

    assign adv = TICK & RUN;

`ifdef KRS_TAIL_EN
    logic [3:0] tail, tail_n;
    logic       tail_valid, tail_valid_n;

    // The tail always records the position before the latest advance, so it
    // coincides with POS while dwelling at an end.
    assign tail_n       = adv ? pos : tail;
    assign tail_valid_n = tail_valid | adv;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            tail       <= 4'd0;
            tail_valid <= 1'b0;
        end else begin
            tail       <= tail_n;
            tail_valid <= tail_valid_n;
        end
    end
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= UP;
            pos   <= 4'd0;
            cnt   <= 4'd0;
            dir   <= 1'b1;
            wrap  <= 1'b0;
            led   <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
            wrap  <= wrap_n;
            led   <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        dir_n   = dir;
        wrap_n  = 1'b0;
        if (adv) begin
            case (state)
                UP: begin
                    if (pos < PMAX) pos_n = pos + 4'd1;
                    if (pos_n >= PMAX) begin
                        if (DW != 4'd0) begin
                            state_n = HOLD_HI;
                            cnt_n   = DW;
                        end else begin
                            state_n = DOWN;
                            dir_n   = 1'b0;
                        end
                    end
                end
                HOLD_HI: begin
                    cnt_n = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_n = DOWN;
                        dir_n   = 1'b0;
                        cnt_n   = 4'd0;
                    end
                end
                DOWN: begin
                    if (pos != 4'd0) pos_n = pos - 4'd1;
                    if (pos_n == 4'd0) begin
                        wrap_n = 1'b1;
                        if (DW != 4'd0) begin
                            state_n = HOLD_LO;
                            cnt_n   = DW;
                        end else begin
                            state_n = UP;
                            dir_n   = 1'b1;
                        end
                    end
                end
                HOLD_LO: begin
                    cnt_n = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_n = UP;
                        dir_n   = 1'b1;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = UP;
                    pos_n   = 4'd0;
                    cnt_n   = 4'd0;
                    dir_n   = 1'b1;
                end
            endcase
        end
    end

    // LED is registered from the next position so it lines up with POS.
    always_comb begin
        led_n = '0;
        if (RUN) begin
            led_n = ONE << pos_n;
`ifdef KRS_TAIL_EN
            if (tail_valid_n) led_n = led_n | (ONE << tail_n);
`endif
        end
    end

    assign LED  = led;
    assign POS  = pos;
    assign DIR  = dir;
    assign WRAP = wrap;

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Directed self-checking bench for knight_rider_scanner; a DWELL=0 and a DWELL=2 instance share stimulus.
module tb_knight_rider_scanner;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       TICK = 1'b0;
    logic       RUN = 1'b0;
    logic [9:0] led0, led2;
    logic [3:0] pos0, pos2;
    logic       dir0, dir2, wrap0, wrap2;
    int         nChecks = 0;
    int         nFails = 0;

    knight_rider_scanner #(.NLEDS(10), .DWELL(0)) dut0 (
        .CLK(CLK), .CLR(CLR), .TICK(TICK), .RUN(RUN),
        .LED(led0), .POS(pos0), .DIR(dir0), .WRAP(wrap0)
    );

    knight_rider_scanner #(.NLEDS(10), .DWELL(2)) dut2 (
        .CLK(CLK), .CLR(CLR), .TICK(TICK), .RUN(RUN),
        .LED(led2), .POS(pos2), .DIR(dir2), .WRAP(wrap2)
    );

    always #5 CLK = ~CLK;

    // Expected bar for the DWELL=0 instance after at least one move.
    function automatic logic [9:0] exp_led(input int p, input int q);
        logic [9:0] v;
        v = 10'd1 << p;
`ifdef KRS_TAIL_EN
        v = v | (10'd1 << q);
`endif
        return v;
    endfunction

    task automatic gap(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_tick();
        TICK = 1'b1;
        @(negedge CLK);
        TICK = 1'b0;
    endtask

    task automatic do_reset();
        CLR = 1'b0; RUN = 1'b0; TICK = 1'b0;
        gap(2);
        CLR = 1'b1; RUN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        CLR = 1'b0; RUN = 1'b1;
        repeat (3) begin
            TICK = 1'b1; @(negedge CLK);
            TICK = 1'b0; @(negedge CLK);
        end
        nChecks++; if (led0 !== 10'd0) begin nFails++; $display("[TB] FAIL reset_led got %b want %b", led0, 10'd0); end
        nChecks++; if (pos0 !== 4'd0) begin nFails++; $display("[TB] FAIL reset_pos got %0d want 0", pos0); end
        nChecks++; if (dir0 !== 1'b1) begin nFails++; $display("[TB] FAIL reset_dir got %b want 1", dir0); end
        nChecks++; if (wrap0 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_wrap got %b want 0", wrap0); end
        CLR = 1'b1;
        @(negedge CLK);
        nChecks++; if (led0 !== 10'b0000000001) begin nFails++; $display("[TB] FAIL release_led got %b want 0000000001", led0); end
        nChecks++; if (pos0 !== 4'd0) begin nFails++; $display("[TB] FAIL release_pos got %0d want 0", pos0); end
    endtask

    task automatic test_scan();
        int ep, prev;
        logic ed, ew;
        do_reset();
        prev = 0;
        for (int k = 1; k <= 18; k++) begin
            pulse_tick();
            ep = (k <= 9) ? k : 18 - k;
            ed = (k >= 9 && k < 18) ? 1'b0 : 1'b1;
            ew = (k == 18);
            nChecks++; if (pos0 !== 4'(ep)) begin nFails++; $display("[TB] FAIL scan_pos tick %0d got %0d want %0d", k, pos0, ep); end
            nChecks++; if (dir0 !== ed) begin nFails++; $display("[TB] FAIL scan_dir tick %0d got %b want %b", k, dir0, ed); end
            nChecks++; if (wrap0 !== ew) begin nFails++; $display("[TB] FAIL scan_wrap tick %0d got %b want %b", k, wrap0, ew); end
            nChecks++; if (led0 !== exp_led(ep, prev)) begin nFails++; $display("[TB] FAIL scan_led tick %0d got %b want %b", k, led0, exp_led(ep, prev)); end
            prev = ep;
            gap(3);
        end
        nChecks++; if (wrap0 !== 1'b0) begin nFails++; $display("[TB] FAIL scan_wrap_width got %b want 0", wrap0); end
    endtask

    task automatic test_dwell();
        int ep;
        logic ed, ew;
        do_reset();
        for (int k = 1; k <= 23; k++) begin
            pulse_tick();
            if (k <= 9)       ep = k;
            else if (k <= 11) ep = 9;
            else if (k <= 19) ep = 20 - k;
            else if (k <= 22) ep = 0;
            else              ep = 1;
            ed = (k <= 10 || k >= 22);
            ew = (k == 20);
            nChecks++; if (pos2 !== 4'(ep)) begin nFails++; $display("[TB] FAIL dwell_pos tick %0d got %0d want %0d", k, pos2, ep); end
            nChecks++; if (dir2 !== ed) begin nFails++; $display("[TB] FAIL dwell_dir tick %0d got %b want %b", k, dir2, ed); end
            nChecks++; if (wrap2 !== ew) begin nFails++; $display("[TB] FAIL dwell_wrap tick %0d got %b want %b", k, wrap2, ew); end
            gap(1);
        end
    endtask

    task automatic test_pause();
        do_reset();
        repeat (5) begin pulse_tick(); gap(1); end
        RUN = 1'b0;
        @(negedge CLK);
        nChecks++; if (led0 !== 10'd0) begin nFails++; $display("[TB] FAIL pause_led got %b want 0", led0); end
        repeat (5) begin pulse_tick(); gap(1); end
        nChecks++; if (pos0 !== 4'd5) begin nFails++; $display("[TB] FAIL pause_pos got %0d want 5", pos0); end
        nChecks++; if (dir0 !== 1'b1) begin nFails++; $display("[TB] FAIL pause_dir got %b want 1", dir0); end
        nChecks++; if (led0 !== 10'd0) begin nFails++; $display("[TB] FAIL pause_led_ticks got %b want 0", led0); end
        RUN = 1'b1;
        @(negedge CLK);
        nChecks++; if (led0 !== exp_led(5, 4)) begin nFails++; $display("[TB] FAIL resume_led got %b want %b", led0, exp_led(5, 4)); end
        pulse_tick();
        nChecks++; if (pos0 !== 4'd6) begin nFails++; $display("[TB] FAIL resume_pos got %0d want 6", pos0); end
    endtask

    task automatic test_async_clear();
        do_reset();
        repeat (11) begin pulse_tick(); gap(1); end
        nChecks++; if (pos0 !== 4'd7 || dir0 !== 1'b0) begin nFails++; $display("[TB] FAIL preclear_state got pos %0d dir %b want pos 7 dir 0", pos0, dir0); end
        #2 CLR = 1'b0;
        #1;
        nChecks++; if (pos0 !== 4'd0) begin nFails++; $display("[TB] FAIL clear_pos got %0d want 0", pos0); end
        nChecks++; if (dir0 !== 1'b1) begin nFails++; $display("[TB] FAIL clear_dir got %b want 1", dir0); end
        nChecks++; if (led0 !== 10'd0) begin nFails++; $display("[TB] FAIL clear_led got %b want 0", led0); end
        nChecks++; if (wrap0 !== 1'b0) begin nFails++; $display("[TB] FAIL clear_wrap got %b want 0", wrap0); end
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_tail();
        do_reset();
        pulse_tick();
`ifdef KRS_TAIL_EN
        nChecks++; if (led0 !== 10'b0000000011) begin nFails++; $display("[TB] FAIL tail_led1 got %b want 0000000011", led0); end
        pulse_tick();
        nChecks++; if (led0 !== 10'b0000000110) begin nFails++; $display("[TB] FAIL tail_led2 got %b want 0000000110", led0); end
        repeat (7) pulse_tick();
        pulse_tick();
        nChecks++; if (led0 !== 10'b1100000000) begin nFails++; $display("[TB] FAIL tail_led_rev got %b want 1100000000", led0); end
`else
        pulse_tick();
        nChecks++; if (led0 !== 10'b0000000100) begin nFails++; $display("[TB] FAIL onehot_led got %b want 0000000100", led0); end
        repeat (8) pulse_tick();
        nChecks++; if (led0 !== 10'b0100000000) begin nFails++; $display("[TB] FAIL onehot_led_rev got %b want 0100000000", led0); end
`endif
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dwell();
        test_pause();
        test_async_clear();
        test_tail();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
